// File: rtl/beta_pkg.sv
// Shared definitions for the BETA program-counter unit: PCSEL encodings,
// default PC width and the default reset/ILLOP/XADR vectors.
package beta_pkg;

    localparam int BETA_W = 32;

    typedef enum logic [2:0] {
        PCSEL_INC   = 3'd0,
        PCSEL_BR    = 3'd1,
        PCSEL_JT    = 3'd2,
        PCSEL_ILLOP = 3'd3,
        PCSEL_XADR  = 3'd4
    } pcsel_e;

    localparam logic [BETA_W-1:0] BETA_RESET_VEC = 32'h8000_0000;
    localparam logic [BETA_W-1:0] BETA_ILLOP_VEC = 32'h8000_0004;
    localparam logic [BETA_W-1:0] BETA_XADR_VEC  = 32'h8000_0008;

    // Only branches and register jumps can be calls.
    function automatic logic is_call_sel(input logic [2:0] sel);
        return (sel == PCSEL_BR) || (sel == PCSEL_JT);
    endfunction

endpackage

// File: rtl/beta_pc_unit_if.sv
// Control/fetch side bundle of the BETA PC unit. master = control unit,
// slave = PC unit.
interface beta_pc_unit_if #(
    parameter int W = 32
);
    logic         STALL;
    logic [2:0]   PCSEL;
    logic [15:0]  ID;
    logic [W-1:0] JT;
    logic         IRQ;
    logic         CALL;
    logic         RET;
    logic [W-1:0] PC;
    logic [W-1:0] PC_INC;
    logic [W-1:0] PC_OFFSET;
    logic         IRQ_TAKEN;
    logic [W-1:0] RAS_TOP;
    logic         RAS_EMPTY;

    modport master (
        output STALL, PCSEL, ID, JT, IRQ, CALL, RET,
        input  PC, PC_INC, PC_OFFSET, IRQ_TAKEN, RAS_TOP, RAS_EMPTY
    );

    modport slave (
        input  STALL, PCSEL, ID, JT, IRQ, CALL, RET,
        output PC, PC_INC, PC_OFFSET, IRQ_TAKEN, RAS_TOP, RAS_EMPTY
    );
endinterface

// File: rtl/beta_ras.sv
// Circular return-address stack: push, pop and replace-top; a push when full
// overwrites the oldest entry.
module beta_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data,
    output logic [W-1:0] top,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] top_idx;

    // ptr_q is the next free slot; when full it also points at the oldest entry
    assign top_idx = ptr_q - PW'(1);
    assign empty   = (cnt_q == '0);
    assign top     = empty ? '0 : mem_q[top_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push && pop) begin
            if (!empty) begin
                mem_q[top_idx] <= data;
            end
        end else if (push) begin
            mem_q[ptr_q] <= data;
            ptr_q        <= ptr_q + PW'(1);
            if (cnt_q != CW'(DEPTH)) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/beta_pc_unit.sv
// BETA program-counter unit: PC register, PC+4/branch/jump targets with
// supervisor protection, latched user-mode interrupt, optional RAS (BETA_PC_RAS_EN).
module beta_pc_unit
    import beta_pkg::*;
#(
    parameter int           W         = BETA_W,
    parameter logic [W-1:0] RESET_VEC = {1'b1, {(W-1){1'b0}}},
    parameter logic [W-1:0] ILLOP_VEC = RESET_VEC + W'(4),
    parameter logic [W-1:0] XADR_VEC  = RESET_VEC + W'(8),
    parameter int           RAS_DEPTH = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    beta_pc_unit_if.slave  bus
);
    logic [W-1:0] pc_q;
    logic [W-1:0] pc_inc;
    logic [W-1:0] pc_offset;
    logic [W-1:0] jmp_tgt;
    logic [W-1:0] pc_nxt;
    logic [W-2:0] br_off;
    logic         irq_pend_q;
    logic         irq_taken_q;
    logic         take_irq;
    logic         unused_jt_lsb;

    // Carry out of bit W-2 is dropped so the supervisor bit never changes here
    assign pc_inc    = {pc_q[W-1], pc_q[W-2:0] + (W-1)'(4)};
    assign br_off    = (W-1)'($signed(bus.ID)) << 2;
    assign pc_offset = {pc_inc[W-1], pc_inc[W-2:0] + br_off};
    // User code may not promote itself to supervisor through a jump
    assign jmp_tgt   = {pc_q[W-1] & bus.JT[W-1], bus.JT[W-2:2], 2'b00};
    assign unused_jt_lsb = ^bus.JT[1:0];

    assign take_irq = !bus.STALL && irq_pend_q && !pc_q[W-1];

    always_comb begin
        pc_nxt = ILLOP_VEC;
        case (bus.PCSEL)
            PCSEL_INC:   pc_nxt = pc_inc;
            PCSEL_BR:    pc_nxt = pc_offset;
            PCSEL_JT:    pc_nxt = jmp_tgt;
            PCSEL_ILLOP: pc_nxt = ILLOP_VEC;
            PCSEL_XADR:  pc_nxt = XADR_VEC;
            default:     pc_nxt = ILLOP_VEC;
        endcase
        if (take_irq) begin
            pc_nxt = XADR_VEC;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q        <= RESET_VEC;
            irq_pend_q  <= 1'b0;
            irq_taken_q <= 1'b0;
        end else begin
            if (!bus.STALL) begin
                pc_q <= pc_nxt;
            end
            irq_taken_q <= take_irq;
            irq_pend_q  <= take_irq ? 1'b0 : (irq_pend_q | bus.IRQ);
        end
    end

    assign bus.PC        = pc_q;
    assign bus.PC_INC    = pc_inc;
    assign bus.PC_OFFSET = pc_offset;
    assign bus.IRQ_TAKEN = irq_taken_q;

`ifdef BETA_PC_RAS_EN
    logic ras_push;
    logic ras_pop;

    // A taken interrupt overrides CALL/RET just as it overrides PCSEL
    assign ras_push = !bus.STALL && !take_irq && bus.CALL && is_call_sel(bus.PCSEL);
    assign ras_pop  = !bus.STALL && !take_irq && bus.RET;

    beta_ras #(
        .W     (W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (CLK),
        .rst   (RESET),
        .push  (ras_push),
        .pop   (ras_pop),
        .data  (pc_inc),
        .top   (bus.RAS_TOP),
        .empty (bus.RAS_EMPTY)
    );
`else
    logic       unused_ras;
    logic [4:0] unused_depth;

    assign unused_ras    = bus.CALL ^ bus.RET;
    assign unused_depth  = 5'(RAS_DEPTH);
    assign bus.RAS_TOP   = '0;
    assign bus.RAS_EMPTY = 1'b1;
`endif

endmodule

// File: tb/tb_beta_pc_unit.sv
// Directed self-checking bench for beta_pc_unit (W=32, RAS_DEPTH=4).
module tb_beta_pc_unit;

    logic CLK;
    logic RESET;
    int   n_asserts = 0;
    int   n_fail    = 0;

    beta_pc_unit_if #(.W(32)) bus ();

    beta_pc_unit #(
        .W         (32),
        .RAS_DEPTH (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h504; ret_exp[1] = 32'h404;
        ret_exp[2] = 32'h304; ret_exp[3] = 32'h204;

        RESET = 1'b1;
        bus.STALL = 1'b0; bus.PCSEL = 3'd3; bus.ID = 16'hFFFF; bus.JT = '0;
        bus.IRQ = 1'b0; bus.CALL = 1'b0; bus.RET = 1'b0;
        #3;
        chk("rst_pc",        bus.PC,        32'h8000_0000);
        chk("rst_pc_inc",    bus.PC_INC,    32'h8000_0004);
        chk("rst_pc_offset", bus.PC_OFFSET, 32'h8000_0000);
        chk("rst_irq_taken", 32'(bus.IRQ_TAKEN), 32'd0);
        chk("rst_ras_empty", 32'(bus.RAS_EMPTY), 32'd1);
        chk("rst_ras_top",   bus.RAS_TOP,   32'd0);
        bus.PCSEL = 3'd4;
        tick();
        chk("rst_hold_pc", bus.PC, 32'h8000_0000);

        RESET = 1'b0; bus.ID = 16'h0000;
        tick();
        chk("xadr_pc", bus.PC, 32'h8000_0008);
        bus.PCSEL = 3'd2; bus.JT = 32'hFFFF_FFFC;
        tick();
        chk("sup_jmp_pc", bus.PC,     32'hFFFF_FFFC);
        chk("sup_wrap",   bus.PC_INC, 32'h8000_0000);
        bus.PCSEL = 3'd0;
        tick();
        chk("inc_wrap_pc", bus.PC, 32'h8000_0000);

        bus.PCSEL = 3'd2; bus.JT = 32'h0000_0010;
        tick();
        chk("to_user_pc", bus.PC, 32'h0000_0010);
        bus.PCSEL = 3'd1; bus.ID = 16'd2;
        #1;
        chk("br_offset", bus.PC_OFFSET, 32'h0000_001C);
        tick();
        chk("br_pc", bus.PC, 32'h0000_001C);
        bus.PCSEL = 3'd2; bus.JT = 32'h8765_4321;
        tick();
        chk("user_jmp_prot", bus.PC, 32'h0765_4320);
        bus.JT = 32'h7FFF_FFFC;
        tick();
        chk("user_wrap", bus.PC_INC, 32'h0000_0000);
        bus.PCSEL = 3'd1; bus.ID = 16'hFFFE;
        #1;
        chk("br_neg_offset", bus.PC_OFFSET, 32'h7FFF_FFF8);
        bus.PCSEL = 3'd6;
        tick();
        chk("reserved_illop", bus.PC, 32'h8000_0004);

        // interrupt latched during a stall, taken once the stall lifts
        bus.PCSEL = 3'd2; bus.JT = 32'h20; bus.ID = 16'd0;
        tick();
        bus.PCSEL = 3'd0; bus.STALL = 1'b1; bus.IRQ = 1'b1;
        tick();
        chk("stall1_pc", bus.PC, 32'h20);
        chk("stall1_taken", 32'(bus.IRQ_TAKEN), 32'd0);
        bus.IRQ = 1'b0;
        tick();
        tick();
        chk("stall3_pc", bus.PC, 32'h20);
        bus.STALL = 1'b0;
        tick();
        chk("irq_pc",    bus.PC, 32'h8000_0008);
        chk("irq_taken", 32'(bus.IRQ_TAKEN), 32'd1);
        tick();
        chk("irq_after_pc",    bus.PC, 32'h8000_000C);
        chk("irq_after_taken", 32'(bus.IRQ_TAKEN), 32'd0);

        // supervisor: request stays pending until user mode
        bus.IRQ = 1'b1;
        tick();
        bus.IRQ = 1'b0;
        tick();
        chk("sup_irq_pc",    bus.PC, 32'h8000_0014);
        chk("sup_irq_taken", 32'(bus.IRQ_TAKEN), 32'd0);
        bus.PCSEL = 3'd2; bus.JT = 32'h40;
        tick();
        chk("sup_ret_pc", bus.PC, 32'h40);
        bus.JT = 32'h100;
        tick();
        chk("pend_irq_pc",    bus.PC, 32'h8000_0008);
        chk("pend_irq_taken", 32'(bus.IRQ_TAKEN), 32'd1);

        // return-address stack
        bus.PCSEL = 3'd2; bus.JT = 32'h100;
        tick();
        bus.CALL = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            bus.JT = 32'(k) << 8;
            tick();
        end
        chk("call_chain_pc", bus.PC, 32'h600);
        bus.PCSEL = 3'd0;
        tick();
        bus.CALL = 1'b0;
`ifdef BETA_PC_RAS_EN
        chk("ras_full_top", bus.RAS_TOP, 32'h504);
        bus.RET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ras_pop_top", bus.RAS_TOP, ret_exp[i]);
            tick();
        end
        chk("ras_empty",     32'(bus.RAS_EMPTY), 32'd1);
        tick();
        chk("ras_extra_empty", 32'(bus.RAS_EMPTY), 32'd1);
        chk("ras_extra_top",   bus.RAS_TOP, 32'd0);
        bus.RET = 1'b0; bus.PCSEL = 3'd2; bus.JT = 32'h700;
        tick();
        bus.CALL = 1'b1; bus.JT = 32'h800;
        tick();
        chk("ras_push_top", bus.RAS_TOP, 32'h704);
        bus.RET = 1'b1; bus.JT = 32'h900;
        tick();
        chk("ras_repl_top",   bus.RAS_TOP, 32'h804);
        chk("ras_repl_empty", 32'(bus.RAS_EMPTY), 32'd0);
        bus.CALL = 1'b0;
        tick();
        bus.RET = 1'b0;
        chk("ras_repl_pop", 32'(bus.RAS_EMPTY), 32'd1);
`else
        chk("ras_off_top",   bus.RAS_TOP, 32'd0);
        chk("ras_off_empty", 32'(bus.RAS_EMPTY), 32'd1);
        bus.RET = 1'b1;
        tick();
        bus.RET = 1'b0;
        chk("ras_off_ret", bus.RAS_TOP, 32'd0);
        for (int i = 0; i < 4; i++) begin
            ret_exp[i] = 32'd0;
        end
`endif

        // asynchronous reset mid-stall with RAS loaded and IRQ pending
        bus.PCSEL = 3'd4;
        tick();
        bus.PCSEL = 3'd2; bus.JT = 32'hFFFF_0000; bus.CALL = 1'b1;
        tick();
        bus.CALL = 1'b0; bus.PCSEL = 3'd0; bus.STALL = 1'b1; bus.IRQ = 1'b1;
        tick();
        bus.IRQ = 1'b0;
        chk("pre_rst_pc", bus.PC, 32'hFFFF_0000);
`ifdef BETA_PC_RAS_EN
        chk("pre_rst_ras", bus.RAS_TOP, 32'h8000_000C);
`endif
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_pc",     bus.PC,     32'h8000_0000);
        chk("async_rst_inc",    bus.PC_INC, 32'h8000_0004);
        chk("async_rst_taken",  32'(bus.IRQ_TAKEN), 32'd0);
        chk("async_rst_empty",  32'(bus.RAS_EMPTY), 32'd1);
        chk("async_rst_top",    bus.RAS_TOP, 32'd0);
        #2;
        RESET = 1'b0; bus.STALL = 1'b0; bus.PCSEL = 3'd2; bus.JT = 32'h40;
        tick();
        chk("post_rst_pc", bus.PC, 32'h40);
        bus.PCSEL = 3'd0;
        tick();
        chk("post_rst_no_irq_pc",    bus.PC, 32'h44);
        chk("post_rst_no_irq_taken", 32'(bus.IRQ_TAKEN), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
